mem_calib_watchdog: RTL
=======================

MEM_CALIB_WATCHDOG -- requirements
Module: mem_calib_watchdog

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 64: sys_reset pulse width in clock cycles, >=2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000000: calibration timeout per attempt in clock cycles, >=2.
REQ-003 SHALL have parameter STABLE_CYCLES, default 16: consecutive synchronized mem_ok-high cycles required before ready, >=1.
REQ-004 SHALL have parameter MAX_RETRY, default 3: timed-out attempts retried before failure, 0..15.
REQ-005 SHALL have port clock  input  1  sole clock.
REQ-006 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port mem_ok  input  1  memory-healthy status, asynchronous to clock.
REQ-008 SHALL have port sw_reset  input  1  synchronous software restart request, level.
REQ-009 SHALL have port sys_reset  output  1  active-high reset request to memory reset control, registered.
REQ-010 SHALL have port mem_ready  output  1  memory calibrated and stable, registered.
REQ-011 SHALL have port calib_failed  output  1  sticky failure flag, registered.
REQ-012 SHALL have port retry_count  output  4  timeouts in current boot sequence.
REQ-013 SHALL have port loss_count  output  8  mem_ok losses seen in READY, saturating.
REQ-014 SHALL have port state  output  3  FSM state for debug: RESET_PULSE=0, WAIT_CALIB=1, STABLE=2, READY=3, FAILED=4.

Function
REQ-015 SHALL synchronize mem_ok through 3 flops reset to 0; mem_ok_s lags mem_ok by 3 cycles.
REQ-016 SHALL keep two counters: tmo_cnt for the attempt timeout, aux_cnt for pulse width and stability; widths are sized from the parameters.
REQ-017 In RESET_PULSE, SHALL drive sys_reset=1 and increment aux_cnt; at aux_cnt==RESET_CYCLES-1 it SHALL go to WAIT_CALIB and clear aux_cnt and tmo_cnt.
REQ-018 In WAIT_CALIB, SHALL drive sys_reset=0 and increment tmo_cnt each cycle.
REQ-019 In WAIT_CALIB, SHALL go to STABLE with aux_cnt=0 when mem_ok_s=1.
REQ-020 In STABLE, SHALL increment aux_cnt and tmo_cnt while mem_ok_s=1; at aux_cnt==STABLE_CYCLES-1 it SHALL go to READY.
REQ-021 In STABLE, SHALL return to WAIT_CALIB on mem_ok_s=0, keeping tmo_cnt so a flapping mem_ok cannot defeat the timeout.
REQ-022 In WAIT_CALIB or STABLE, when tmo_cnt==TIMEOUT_CYCLES-1 with no other transition: if retry_count==MAX_RETRY it SHALL go to FAILED, else it SHALL increment retry_count and go to RESET_PULSE with aux_cnt=0.
REQ-023 The STABLE-to-READY transition SHALL take priority over a timeout in the same cycle.
REQ-024 In READY, SHALL drive mem_ready=1; on mem_ok_s=0 it SHALL increment loss_count (saturating at 255), clear retry_count and go to RESET_PULSE.
REQ-025 mem_ready SHALL be 1 exactly while state==READY; it SHALL drop in the cycle after the mem_ok_s loss.
REQ-026 FAILED SHALL drive calib_failed=1 and sys_reset=1 (memory held in reset) and is terminal except via sw_reset or aresetn.
REQ-027 sw_reset=1 in any state SHALL force RESET_PULSE next cycle with aux_cnt=0, retry_count=0 and calib_failed=0; it SHALL hold RESET_PULSE while asserted and SHALL take priority over all other transitions.
REQ-028 loss_count SHALL clear only on aresetn.

Reset
REQ-029 aresetn=0 SHALL asynchronously set state=RESET_PULSE, sys_reset=1, mem_ready=0, calib_failed=0, retry_count=0, loss_count=0, counters=0 and synchronizer=0.
REQ-030 After aresetn deasserts, the block SHALL start a full RESET_PULSE of RESET_CYCLES cycles.
REQ-031 aresetn mid-operation SHALL abandon any attempt immediately with no glitch on mem_ready.

Verification (RESET_CYCLES=4, TIMEOUT_CYCLES=20, STABLE_CYCLES=5, MAX_RETRY=2)
REQ-032 Normal boot: release aresetn, mem_ok=1 held -> sys_reset=1 for 4 cycles, then mem_ready=1 after 3 sync + 1 WAIT + 5 STABLE cycles; retry_count=0.
REQ-033 Timeout/retry: mem_ok=0 forever -> 3 attempts, retry_count 0->1->2, then FAILED: calib_failed=1, sys_reset=1, state=4; a sw_reset pulse -> calib_failed=0 and retry_count=0.
REQ-034 Flap: mem_ok toggling every 3 cycles -> READY never reached; timeout still fires 20 cycles after WAIT_CALIB entry.
REQ-035 Loss in READY: drop mem_ok -> mem_ready=0 4 cycles later (3 sync + 1), loss_count=1, new 4-cycle sys_reset pulse; repeat 300 times -> loss_count=255.
REQ-036 Race: stability completes on the same cycle as tmo_cnt==19 -> READY, not a retry; aresetn pulsed while in STABLE -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/mem_calib_watchdog.sv
// Memory calibration watchdog: pulses the memory reset, waits for a stable
// mem_ok, retries timed-out attempts and latches a failure after MAX_RETRY.
module mem_calib_watchdog #(
    parameter int unsigned RESET_CYCLES   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic       mem_ok,
    input  logic       sw_reset,
    output logic       sys_reset,
    output logic       mem_ready,
    output logic       calib_failed,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam int unsigned AUX_MAX = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
    localparam int unsigned AUX_W   = $clog2(AUX_MAX);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [AUX_W-1:0] AUX_RST_LAST = AUX_W'(RESET_CYCLES - 1);
    localparam logic [AUX_W-1:0] AUX_STB_LAST = AUX_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET_PULSE = 3'd0,
        ST_WAIT_CALIB  = 3'd1,
        ST_STABLE      = 3'd2,
        ST_READY       = 3'd3,
        ST_FAILED      = 3'd4
    } state_t;

    state_t           r_state;
    logic [2:0]       r_sync;
    logic [AUX_W-1:0] r_aux;
    logic [TMO_W-1:0] r_tmo;
    logic [3:0]       r_retry;
    logic [7:0]       r_loss;
    logic             r_sys_reset;
    logic             r_mem_ready;
    logic             r_calib_failed;

    state_t           w_state_nxt;
    logic [AUX_W-1:0] w_aux_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic [3:0]       w_retry_nxt;
    logic [7:0]       w_loss_nxt;
    logic             w_mem_ok_s;
    logic             w_tmo_done;
    logic [TMO_W-1:0] w_tmo_inc;

    assign w_mem_ok_s = r_sync[2];
    assign w_tmo_done = (r_tmo == TMO_LAST);
    // Saturating: a timeout deferred by a competing transition fires on the
    // next eligible cycle instead of wrapping.
    assign w_tmo_inc  = w_tmo_done ? r_tmo : r_tmo + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_aux_nxt   = r_aux;
        w_tmo_nxt   = r_tmo;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        if (sw_reset) begin
            w_state_nxt = ST_RESET_PULSE;
            w_aux_nxt   = '0;
            w_tmo_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_RESET_PULSE: begin
                    if (r_aux == AUX_RST_LAST) begin
                        w_state_nxt = ST_WAIT_CALIB;
                        w_aux_nxt   = '0;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_aux_nxt = r_aux + 1'b1;
                    end
                end
                ST_WAIT_CALIB: begin
                    w_tmo_nxt = w_tmo_inc;
                    if (w_mem_ok_s) begin
                        w_state_nxt = ST_STABLE;
                        w_aux_nxt   = '0;
                    end else if (w_tmo_done) begin
                        if (r_retry == RETRY_LIMIT) begin
                            w_state_nxt = ST_FAILED;
                        end else begin
                            w_state_nxt = ST_RESET_PULSE;
                            w_retry_nxt = r_retry + 4'd1;
                            w_aux_nxt   = '0;
                        end
                    end
                end
                ST_STABLE: begin
                    w_tmo_nxt = w_tmo_inc;
                    if (!w_mem_ok_s) begin
                        w_state_nxt = ST_WAIT_CALIB;
                    end else if (r_aux == AUX_STB_LAST) begin
                        w_state_nxt = ST_READY;
                    end else if (w_tmo_done) begin
                        w_aux_nxt = '0;
                        if (r_retry == RETRY_LIMIT) begin
                            w_state_nxt = ST_FAILED;
                        end else begin
                            w_state_nxt = ST_RESET_PULSE;
                            w_retry_nxt = r_retry + 4'd1;
                        end
                    end else begin
                        w_aux_nxt = r_aux + 1'b1;
                    end
                end
                ST_READY: begin
                    if (!w_mem_ok_s) begin
                        w_state_nxt = ST_RESET_PULSE;
                        w_aux_nxt   = '0;
                        w_retry_nxt = '0;
                        w_loss_nxt  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                    end
                end
                ST_FAILED: begin
                    w_state_nxt = ST_FAILED;
                end
                default: begin
                    w_state_nxt = ST_RESET_PULSE;
                    w_aux_nxt   = '0;
                    w_tmo_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= ST_RESET_PULSE;
            r_sync         <= '0;
            r_aux          <= '0;
            r_tmo          <= '0;
            r_retry        <= '0;
            r_loss         <= '0;
            r_sys_reset    <= 1'b1;
            r_mem_ready    <= 1'b0;
            r_calib_failed <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sync         <= {r_sync[1:0], mem_ok};
            r_aux          <= w_aux_nxt;
            r_tmo          <= w_tmo_nxt;
            r_retry        <= w_retry_nxt;
            r_loss         <= w_loss_nxt;
            r_sys_reset    <= (w_state_nxt == ST_RESET_PULSE) || (w_state_nxt == ST_FAILED);
            r_mem_ready    <= (w_state_nxt == ST_READY);
            r_calib_failed <= (w_state_nxt == ST_FAILED);
        end
    end

    assign sys_reset    = r_sys_reset;
    assign mem_ready    = r_mem_ready;
    assign calib_failed = r_calib_failed;
    assign retry_count  = r_retry;
    assign loss_count   = r_loss;
    assign state        = r_state;

endmodule
